// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - start/busy/done handshake and operand/result bus of the shift sequencer
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [31:0]      shift_amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;

  modport master (
    output start, op, data_in, shift_amount,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, data_in, shift_amount,
    output busy, done, data_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative SHL/SHR/SHRA/ROL/ROR unit, STEP bits per cycle
// Define SHIFT_SEQ_FASTPATH_EN to finish any nonzero count in a single RUN cycle.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = 5
) (
  input  logic clock,
  input  logic clear,
  shift_sequencer_if.slave bus
);

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [AMT_W:0] STEP_C = (AMT_W+1)'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] amt;
  logic [AMT_W-1:0] k;
  logic [WIDTH-1:0] shifted;
  logic             unused_amt_hi;

  assign unused_amt_hi = ^bus.shift_amount[31:AMT_W];

  // Rotates go through a doubled word so a count of 0 needs no special case.
  function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] v,
                                                input logic [2:0] o,
                                                input logic [AMT_W-1:0] n);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v};
    case (o)
      OP_SHL:  shift_op = v << n;
      OP_SHR:  shift_op = v >> n;
      OP_SHRA: shift_op = $signed(v) >>> n;
      OP_ROL:  begin dbl = dbl << n; shift_op = dbl[2*WIDTH-1 -: WIDTH]; end
      OP_ROR:  begin dbl = dbl >> n; shift_op = dbl[WIDTH-1:0]; end
      default: shift_op = v;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    op_d       = op_q;
    data_out_d = data_out_q;
    k          = '0;
    shifted    = '0;
    amt        = bus.shift_amount[AMT_W-1:0];
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          op_d  = bus.op;
          acc_d = bus.data_in;
          rem_d = amt;
          if (amt == '0 || bus.op > OP_ROR) begin
            state_d    = DONE;
            rem_d      = '0;
            data_out_d = bus.data_in;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
`ifdef SHIFT_SEQ_FASTPATH_EN
        k = rem_q;
`else
        k = ({1'b0, rem_q} < STEP_C) ? rem_q : STEP_C[AMT_W-1:0];
`endif
        shifted = shift_op(acc_q, op_q, k);
        acc_d   = shifted;
        rem_d   = rem_q - k;
        if (rem_q == k) begin
          state_d    = DONE;
          data_out_d = shifted;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      op_q       <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized bench for shift_sequencer, STEP=1 and STEP=4 instances in lockstep
module tb_shift_sequencer;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  shift_sequencer_if #(.WIDTH(32)) bus1 ();
  shift_sequencer_if #(.WIDTH(32)) bus4 ();

  shift_sequencer #(.WIDTH(32), .STEP(1), .AMT_W(5)) u_dut1 (
    .clock(clock), .clear(clear), .bus(bus1)
  );
  shift_sequencer #(.WIDTH(32), .STEP(4), .AMT_W(5)) u_dut4 (
    .clock(clock), .clear(clear), .bus(bus4)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] d,
                       input logic [31:0] sa);
    bus1.start = s; bus1.op = o; bus1.data_in = d; bus1.shift_amount = sa;
    bus4.start = s; bus4.op = o; bus4.data_in = d; bus4.shift_amount = sa;
  endtask

  // One bit at a time, straight from the op definitions.
  function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] v,
                                            input logic [31:0] sa);
    int amt = int'(sa % 32);
    for (int i = 0; i < amt; i++) begin
      case (o)
        3'd0: v = v * 2;
        3'd1: v = v / 2;
        3'd2: v = (v / 2) | (v & 32'h8000_0000);
        3'd3: v = (v * 2) | (v / 32'h8000_0000);
        3'd4: v = (v / 2) | ((v % 2) * 32'h8000_0000);
        default: ;
      endcase
    end
    return v;
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [31:0] sa, input int step);
    int amt = int'(sa % 32);
    if (amt == 0 || o > 3'd4) return 0;
`ifdef SHIFT_SEQ_FASTPATH_EN
    return 1;
`else
    return (amt + step - 1) / step;
`endif
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] sa,
                        input bit chain_req, input string tag);
    logic [31:0] r;
    int n1, n4, nmax, nmin;
    bit chain;
    r    = ref_shift(o, d, sa);
    n1   = lat(o, sa, 1);
    n4   = lat(o, sa, 4);
    nmax = (n1 > n4) ? n1 : n4;
    nmin = (n1 < n4) ? n1 : n4;
    chain = chain_req && (n1 == n4);
    drive(1'b1, o, d, sa);
    @(posedge clock);
    #1 drive(chain, 3'($urandom), $urandom, $urandom);
    for (int j = 0; j <= nmax; j++) begin
      @(negedge clock);
      check($sformatf("%s busy1 j%0d", tag, j), {31'b0, bus1.busy}, (j < n1) ? 32'd1 : 32'd0);
      check($sformatf("%s done1 j%0d", tag, j), {31'b0, bus1.done}, (j == n1) ? 32'd1 : 32'd0);
      check($sformatf("%s dout1 j%0d", tag, j), bus1.data_out, (j < n1) ? exp_prev : r);
      check($sformatf("%s busy4 j%0d", tag, j), {31'b0, bus4.busy}, (j < n4) ? 32'd1 : 32'd0);
      check($sformatf("%s done4 j%0d", tag, j), {31'b0, bus4.done}, (j == n4) ? 32'd1 : 32'd0);
      check($sformatf("%s dout4 j%0d", tag, j), bus4.data_out, (j < n4) ? exp_prev : r);
      if (!chain)
        drive((j < nmin) ? 1'($urandom) : 1'b0, 3'($urandom), $urandom, $urandom);
    end
    exp_prev = r;
  endtask

  initial begin
    clear = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clock);
    check("rst busy", {30'b0, bus1.busy, bus4.busy}, 32'd0);
    check("rst done", {30'b0, bus1.done, bus4.done}, 32'd0);
    check("rst dout1", bus1.data_out, 32'd0);
    check("rst dout4", bus4.data_out, 32'd0);
    clear = 1'b1;

    run_op(3'd0, 32'd5, 32'd3, 1'b0, "shl5");
    run_op(3'd0, 32'd6, 32'd1, 1'b0, "shl6");
    run_op(3'd2, 32'h8000_0000, 32'd31, 1'b0, "shra");
    run_op(3'd1, 32'h8000_0000, 32'd31, 1'b0, "shr");
    run_op(3'd3, 32'h8000_0001, 32'd4, 1'b0, "rol");
    run_op(3'd4, 32'h8000_0001, 32'd36, 1'b0, "ror");
    run_op(3'd0, 32'h0000_1234, 32'd0, 1'b0, "zero");
    run_op(3'd7, $urandom, 32'd7, 1'b0, "pass");
    run_op(3'd0, $urandom, 32'd1, 1'b1, "b2b_a");
    run_op(3'd1, $urandom, 32'd4, 1'b0, "b2b_b");

    // Abort a 10-bit SHL while both instances are still running.
    drive(1'b1, 3'd0, $urandom, 32'd10);
    @(posedge clock);
    #1 drive(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("clr busy", {30'b0, bus1.busy, bus4.busy}, 32'd0);
    check("clr dout1", bus1.data_out, 32'd0);
    check("clr dout4", bus4.data_out, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("clr done c%0d", i), {30'b0, bus1.done, bus4.done}, 32'd0);
    end
    clear = 1'b1;
    exp_prev = '0;
    @(negedge clock);
    check("post clr done", {30'b0, bus1.done, bus4.done}, 32'd0);
    run_op(3'd0, 32'h0000_00ff, 32'd10, 1'b0, "after_clr");

    for (int t = 0; t < 60; t++) begin
      logic [31:0] sa;
      sa = ($urandom % 4 == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom;
      run_op(3'($urandom_range(0, 7)), $urandom, sa, ($urandom % 3) == 0,
             $sformatf("rnd%0d", t));
    end
    run_op(3'd2, $urandom, 32'd9, 1'b0, "last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift/rotate execution unit. It sits between the operand registers (Y / bus operand) and the Z result register.
- It implements the datapath shift ops SHL, SHR, SHRA, ROL and ROR iteratively, STEP bits per clock.
- A start/busy/done handshake lets the control unit stall until the result is valid for the Z capture.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of 2.
- STEP, 1, maximum bits shifted per RUN cycle; legal values 1, 2, 4, 8.
- AMT_W, 5, shift-count bits taken from shift_amount; equals log2(WIDTH).

Ports:
- clock  input  1  rising-edge system clock
- clear  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- op  input  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 pass-through
- data_in  input  WIDTH  operand to shift; signed for SHRA
- shift_amount  input  32  shift count; only bits [AMT_W-1:0] are used
- busy  output  1  high while a shift is in progress
- done  output  1  single-cycle pulse; data_out is valid from this cycle on
- data_out  output  WIDTH  result; held until the next accepted start

Behaviour:
- Reset (clear=0, any time, asynchronous):
  - state=IDLE, data_out=0, busy=0, done=0, internal accumulator and counter = 0.
  - An operation in flight is abandoned; no done is produced for it.
- States are IDLE, RUN and DONE.
- IDLE: start=1 at edge E0 latches data_in, op, and amt=shift_amount[AMT_W-1:0].
  - If amt==0 or op is pass-through, go to DONE.
  - Otherwise go to RUN with remaining=amt.
- RUN: busy=1. Each edge applies k=min(STEP, remaining) bits of the latched op to the accumulator, then remaining-=k.
  - Leave for DONE on the edge where remaining becomes 0.
  - start is ignored in RUN; inputs may change freely.
- DONE: done=1 and busy=0 for exactly one cycle; data_out=final accumulator, loaded on the edge entering DONE.
  - Next state is IDLE, or a new operation if start=1 (back-to-back accepted; same rules as IDLE).
- Latency: with N=ceil(amt/STEP), done is high in the cycle that begins at edge E0+N. For amt=0 that is the cycle right after E0.
- Op semantics per bit step:
  - SHL: zero fill at the LSB.
  - SHR: zero fill at the MSB.
  - SHRA: the MSB is replicated.
  - ROL / ROR: circular.
  - A count of 0 yields data_in unchanged.
- Shift counts are taken mod WIDTH. For example, shift_amount=35 gives amt=3, and upper shift_amount bits never cause a zero result.
- data_out changes only on entry to DONE, or on reset. It is stable in IDLE and RUN.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro: SHIFT_SEQ_FASTPATH_EN.
- Defined:
  - RUN is replaced by a single-cycle barrel shift: any nonzero amt completes in one RUN cycle, so N=1 for all amt>0 and N=0 for amt=0.
  - STEP is ignored.
- Undefined: iterative behaviour exactly as above.
- Results are identical in both builds; only the latency differs.

Test Plan:
- Reset then SHL: clear low 2 cycles then high; start, op=000, data_in=5, shift_amount=3, STEP=1.
  - Response: busy high for 3 cycles, done at E0+3, data_out=40; data_out=0 before this.
- SHL: data_in=6, shift_amount=1.
  - Response: done at E0+1, data_out=12.
- SHRA: data_in=0x80000000, shift_amount=31, STEP=4.
  - Response: done at E0+8, data_out=0xFFFFFFFF.
- SHR with the same operands as the SHRA case.
  - Response: data_out=0x00000001.
- ROL: data_in=0x80000001, shift_amount=4.
  - Response: data_out=0x00000018.
- ROR: data_in=0x80000001, shift_amount=36 (masked to 4).
  - Response: data_out=0x18000000.
- Zero count and pass-through:
  - shift_amount=0 with op=SHL and data_in=0x1234 → done at E0, no busy, data_out=0x1234.
  - op=111 with shift_amount=7 → data_out=data_in.
- Handshake edge cases:
  - start pulsed mid-RUN is ignored and the original result is unchanged.
  - start held high in DONE launches the next op back-to-back.
  - clear asserted mid-RUN of a 10-bit SHL → outputs 0 immediately, no done pulse, and the next op runs correctly.
